// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared sizes and entry record for the store buffer
package sb_pkg;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int WADDR_W = ADDR_W - 2;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - CPU data port and data_memory port seen by the store buffer
interface store_buffer_if;
    import sb_pkg::*;

    logic [ADDR_W-1:0] cpu_a;
    logic              cpu_we;
    logic              cpu_re;
    logic [DATA_W-1:0] cpu_wd;
    logic [DATA_W-1:0] cpu_rd;
    logic              stall;
    logic              empty;
    logic              flush;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_ready;

    modport slave (
        input  cpu_a, cpu_we, cpu_re, cpu_wd, flush, mem_rd, mem_ready,
        output cpu_rd, stall, empty, mem_a, mem_we, mem_wd
    );

    modport master (
        output cpu_a, cpu_we, cpu_re, cpu_wd, flush, mem_rd, mem_ready,
        input  cpu_rd, stall, empty, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - circular store queue with a flat view for forwarding
module store_buffer_fifo
    import sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  sb_entry_t        i_wr_entry,
    output sb_entry_t        o_head_entry,
    output sb_entry_t        o_entries [DEPTH],
    output logic [PTR_W-1:0] o_head,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);
    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop)  r_head <= r_head + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents need no reset; only count-qualified slots are ever used.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_tail] <= i_wr_entry;
    end

    assign o_head_entry = r_mem[r_head];
    assign o_entries    = r_mem;
    assign o_head       = r_head;
    assign o_count      = r_count;
    assign o_full       = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty      = (r_count == '0);
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer between CPU data port and data_memory
module store_buffer
    import sb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);
    sb_entry_t        w_head_entry;
    sb_entry_t        w_entries [DEPTH];
    sb_entry_t        w_wr_entry;
    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W:0]   w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_load;
    logic             w_drain;
    logic             w_pop;
    logic             w_push;
    logic             w_stall;
    logic             w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    store_buffer_fifo u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_wr_entry   (w_wr_entry),
        .o_head_entry (w_head_entry),
        .o_entries    (w_entries),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // A load owns the memory port; a store request never blocks draining.
    assign w_load  = bus.cpu_re & ~bus.cpu_we;
    assign w_drain = ~w_load & ~w_empty;
    assign w_pop   = w_drain & bus.mem_ready;

    assign w_stall = (bus.cpu_we & w_full & ~w_pop) | (bus.flush & ~w_empty);
    assign w_push  = bus.cpu_we & ~w_stall;

    assign w_wr_entry = '{waddr: bus.cpu_a[ADDR_W-1:2], data: bus.cpu_wd};

    assign bus.mem_we = w_drain;
    assign bus.mem_a  = w_drain ? {w_head_entry.waddr, 2'b00} : bus.cpu_a;
    assign bus.mem_wd = w_head_entry.data;
    assign bus.stall  = w_stall;
    assign bus.empty  = w_empty;

    // Oldest to youngest, so a later match overrides an earlier one.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_head + PTR_W'(i);
            if (((PTR_W+1)'(i) < w_count) &&
                (w_entries[w_idx].waddr == bus.cpu_a[ADDR_W-1:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_entries[w_idx].data;
            end
        end
    end

    assign bus.cpu_rd = w_fwd_hit ? w_fwd_data : bus.mem_rd;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
    import sb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    store_buffer_if sbif ();

    store_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory: 256 words, seeded with a recognisable pattern
    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];

    assign sbif.mem_rd = dmem[sbif.mem_a[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'hD000_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (sbif.mem_we && sbif.mem_ready) dmem[sbif.mem_a[9:2]] <= sbif.mem_wd;
        end
    end

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
    } m_t;
    m_t q[$];

    typedef struct {
        logic        we, re, fl, rdy;
        logic [31:0] a, wd;
        logic        e_stall, e_mwe, e_empty, chk_rd;
        logic [31:0] e_rd;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t v(logic we, logic re, logic fl, logic rdy,
                               logic [31:0] a, logic [31:0] wd,
                               logic es, logic em, logic ee,
                               logic erc, logic [31:0] er);
        vec_t t;
        t.we = we; t.re = re; t.fl = fl; t.rdy = rdy; t.a = a; t.wd = wd;
        t.e_stall = es; t.e_mwe = em; t.e_empty = ee; t.chk_rd = erc; t.e_rd = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the queue model, then advance it.
    task automatic cycle(input logic we, input logic re, input logic fl, input logic rdy,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic tchk, input logic es, input logic em,
                         input logic ee, input logic erc, input logic [31:0] er);
        logic load, drain, pop, st, push, hit;
        logic [31:0] exp_rd;
        sbif.cpu_we = we; sbif.cpu_re = re; sbif.flush = fl; sbif.mem_ready = rdy;
        sbif.cpu_a = a; sbif.cpu_wd = wd;
        #1;
        load  = re && !we;
        drain = !load && (q.size() > 0);
        pop   = drain && rdy;
        st    = (we && (q.size() == DEPTH) && !pop) || (fl && (q.size() != 0));
        push  = we && !st;
        check("model_stall", 32'(sbif.stall), 32'(st));
        check("model_mem_we", 32'(sbif.mem_we), 32'(drain));
        check("model_empty", 32'(sbif.empty), 32'(q.size() == 0));
        if (drain) begin
            check("model_mem_a", sbif.mem_a, {q[0].wa, 2'b00});
            check("model_mem_wd", sbif.mem_wd, q[0].d);
        end
        if (load) begin
            hit = 1'b0;
            exp_rd = ref_mem[a[9:2]];
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].wa == a[31:2]) begin
                    hit = 1'b1;
                    exp_rd = q[i].d;
                end
            end
            check("model_cpu_rd", sbif.cpu_rd, exp_rd);
        end
        if (tchk) begin
            check("tbl_stall", 32'(sbif.stall), 32'(es));
            check("tbl_mem_we", 32'(sbif.mem_we), 32'(em));
            check("tbl_empty", 32'(sbif.empty), 32'(ee));
            if (erc) check("tbl_cpu_rd", sbif.cpu_rd, er);
        end
        @(posedge clk);
        if (pop) begin
            ref_mem[q[0].wa[7:0]] = q[0].d;
            void'(q.pop_front());
        end
        if (push) q.push_back('{wa: a[31:2], d: wd});
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, rdy, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int nbad;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hD000_0000 + 32'(i);
        rst_n = 1'b0;
        sbif.cpu_we = 1'b0; sbif.cpu_re = 1'b0; sbif.flush = 1'b0; sbif.mem_ready = 1'b0;
        sbif.cpu_a = '0; sbif.cpu_wd = '0;
        #1;
        check("reset_empty", 32'(sbif.empty), 32'd1);
        check("reset_stall", 32'(sbif.stall), 32'd0);
        check("reset_mem_we", 32'(sbif.mem_we), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // in-order drain
        vq.push_back(v(1,0,0,1,32'h10,32'h11, 0,0,1, 0,0));
        vq.push_back(v(1,0,0,1,32'h14,32'h22, 0,1,0, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,1,0, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,0,1, 0,0));
        vq.push_back(v(0,1,0,1,32'h10,0,      0,0,1, 1,32'h11));
        vq.push_back(v(0,1,0,1,32'h14,0,      0,0,1, 1,32'h22));
        // full buffer with memory busy, then pop+push on release
        vq.push_back(v(1,0,0,0,32'h80,32'h1,  0,0,1, 0,0));
        vq.push_back(v(1,0,0,0,32'h84,32'h2,  0,1,0, 0,0));
        vq.push_back(v(1,0,0,0,32'h88,32'h3,  0,1,0, 0,0));
        vq.push_back(v(1,0,0,0,32'h8C,32'h4,  0,1,0, 0,0));
        vq.push_back(v(1,0,0,0,32'h90,32'h5,  1,1,0, 0,0));
        vq.push_back(v(1,0,0,0,32'h90,32'h5,  1,1,0, 0,0));
        vq.push_back(v(1,0,0,1,32'h90,32'h5,  0,1,0, 0,0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,0,0,1,0,0, 0,1,0, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,0,1, 0,0));
        vq.push_back(v(0,1,0,1,32'h90,0,      0,0,1, 1,32'h5));
        // youngest-match forwarding, store wins over load
        vq.push_back(v(1,0,0,0,32'h20,32'hAA, 0,0,1, 0,0));
        vq.push_back(v(1,0,0,0,32'h20,32'hBB, 0,1,0, 0,0));
        vq.push_back(v(0,1,0,0,32'h22,0,      0,0,0, 1,32'hBB));
        vq.push_back(v(1,1,0,0,32'h24,32'hCC, 0,1,0, 0,0));
        for (int i = 0; i < 3; i++) vq.push_back(v(0,0,0,1,0,0, 0,1,0, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,0,1, 0,0));
        vq.push_back(v(0,1,0,1,32'h20,0,      0,0,1, 1,32'hBB));
        // loads pre-empt draining
        vq.push_back(v(1,0,0,0,32'h200,32'h61,0,0,1, 0,0));
        vq.push_back(v(1,0,0,0,32'h204,32'h62,0,1,0, 0,0));
        vq.push_back(v(1,0,0,0,32'h208,32'h63,0,1,0, 0,0));
        vq.push_back(v(0,1,0,1,32'h40,0,      0,0,0, 1,32'hD000_0010));
        vq.push_back(v(0,1,0,1,32'h40,0,      0,0,0, 1,32'hD000_0010));
        for (int i = 0; i < 3; i++) vq.push_back(v(0,0,0,1,0,0, 0,1,0, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,0,1, 0,0));
        // flush with three pending
        vq.push_back(v(1,0,0,0,32'h300,32'h71,0,0,1, 0,0));
        vq.push_back(v(1,0,0,0,32'h304,32'h72,0,1,0, 0,0));
        vq.push_back(v(1,0,0,0,32'h308,32'h73,0,1,0, 0,0));
        for (int i = 0; i < 3; i++) vq.push_back(v(0,0,1,1,0,0, 1,1,0, 0,0));
        vq.push_back(v(0,0,1,1,0,0,           0,0,1, 0,0));
        vq.push_back(v(1,0,1,1,32'h30C,32'h77,0,0,1, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,1,0, 0,0));
        vq.push_back(v(0,0,0,1,0,0,           0,0,1, 0,0));

        foreach (vq[k])
            cycle(vq[k].we, vq[k].re, vq[k].fl, vq[k].rdy, vq[k].a, vq[k].wd,
                  1'b1, vq[k].e_stall, vq[k].e_mwe, vq[k].e_empty, vq[k].chk_rd, vq[k].e_rd);

        check("dmem_word4", dmem[4], 32'h11);
        check("dmem_word5", dmem[5], 32'h22);

        // asynchronous reset with two pending stores
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h3F0, 32'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h3F4, 32'h82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        sbif.cpu_we = 1'b0; sbif.mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(sbif.empty), 32'd1);
        check("arst_mem_we", 32'(sbif.mem_we), 32'd0);
        check("arst_stall", 32'(sbif.stall), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("arst_word_fc", dmem[252], 32'hD000_00FC);
        check("arst_word_fd", dmem[253], 32'hD000_00FD);

        // randomized traffic over a small address window to exercise forwarding
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra;
            ra = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  ra, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        nbad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) nbad++;
        check("dmem_image", 32'(nbad), 32'd0);
        check("final_empty", 32'(sbif.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the data port of mips_cpu and data_memory.
- CPU stores are accepted in one cycle into a small FIFO, then drained to data_memory one word per cycle whenever the memory port is free.
- CPU loads go straight to memory, with youngest-match forwarding from the buffer.
- A stall output tells the CPU/PC logic to hold when the buffer is full and cannot drain.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >= 2)
ADDR_W, 32, byte address width
DATA_W, 32, data word width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cpu_a  input  ADDR_W  byte address from CPU (word access only; bits [1:0] ignored)
cpu_we  input  1  CPU store request
cpu_re  input  1  CPU load request
cpu_wd  input  DATA_W  store data
cpu_rd  output  DATA_W  load data returned to CPU (combinational)
stall  output  1  CPU must hold PC and repeat the current instruction
empty  output  1  buffer holds no pending stores
flush  input  1  drain request; stall asserted until empty
mem_a  output  ADDR_W  data_memory address
mem_we  output  1  data_memory write enable
mem_wd  output  DATA_W  data_memory write data
mem_rd  input  DATA_W  data_memory read data
mem_ready  input  1  memory accepts the write this cycle (tie to 1 for the current data_memory)

Behaviour:
- State: entry arrays addr[DEPTH] (word address ADDR_W-2 bits) and data[DEPTH]; head and tail pointers of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
- Reset (async, rst_n=0): head=tail=0, count=0, so empty=1, stall=0, mem_we=0. Entry contents are don't-care. Reset mid-drain discards all pending stores.
- Priority: if cpu_we and cpu_re are both 1, the access is treated as a store and cpu_re is ignored.
- Memory port mux (combinational):
  - cpu_re=1 and cpu_we=0: mem_a=cpu_a, mem_we=0. No drain this cycle.
  - Otherwise, when count>0: mem_a={addr[head],2'b00}, mem_wd=data[head], mem_we=1.
  - Otherwise: mem_we=0, mem_a=cpu_a.
- pop = mem_we & mem_ready. At the clock edge head increments, wrapping modulo DEPTH.
- push = cpu_we & ~stall. At the clock edge, entry[tail]={cpu_a[ADDR_W-1:2], cpu_wd} and tail increments, wrapping.
- Simultaneous push and pop: count unchanged. Allowed when full, because pop frees the head slot before the write lands at tail (tail==head when full).
- stall = (cpu_we & (count==DEPTH) & ~pop) | (flush & (count!=0)). Stall does not depend on the stall-suppressed push (no combinational loop).
- Load forwarding:
  - cpu_rd = data of the youngest valid entry whose addr equals cpu_a[ADDR_W-1:2]; otherwise mem_rd.
  - Search runs tail-1 back to head, over count entries only.
  - No partial-word merging.
- A store and a same-address load never coexist in one cycle (store wins).
- Latency: store visible to loads in the next cycle via forwarding, and in data_memory at least 1 cycle after push.
- empty = (count==0).
- Pop never occurs when count==0. Push never occurs when count==DEPTH && ~pop.

Decomposition:
- Shared package (sb_pkg): DEPTH, ADDR_W, DATA_W, PTR_W=log2(DEPTH), and the entry record type {word address, data}.
- One sub-module, store_buffer_fifo, holds the storage, pointers and count. It exposes head entry, full/empty and a flat view of entries for the forwarding search.
- Top level keeps the port mux, stall and forwarding logic.

Test Plan:
- Store 0x11 to 0x10, then 0x22 to 0x14, with mem_ready=1 and no loads. Expected: mem_we pulses once per cycle with the same data in order; empty=1 after 2 drain cycles; data_memory word 4=0x11, word 5=0x22.
- Hold mem_ready=0 and issue 5 stores (DEPTH=4). Expected: stall=1 on the 5th store; count stays 4. Raise mem_ready: 5th store accepted in the same cycle as the pop; stall=0.
- Store 0xAA to 0x20, then 0xBB to 0x20, then load 0x20 while both are pending. Expected: cpu_rd=0xBB (youngest wins); mem_we=0 during the load cycle.
- Back-to-back loads of 0x40 with 3 pending stores to other addresses. Expected: cpu_rd=mem_rd; no drain in load cycles; drain resumes on the first non-load cycle.
- Assert flush with 3 pending stores. Expected: stall=1 for exactly 3 cycles (mem_ready=1), then stall=0 and empty=1.
- Drop rst_n asynchronously mid-clock with 2 pending stores. Expected: empty=1, mem_we=0, stall=0 immediately; no further writes reach memory.
